// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the display scanner and its decoder.
// Segment patterns are active-high {g,f,e,d,c,b,a}; output polarity is applied later.
package seg_pkg;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit act_lo);
    return act_lo ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Display scanner bus: control/value inputs from the host, scanned digit drive back out.
// The master side drives value and control; the slave side is the scanner itself.
interface seg_display_scanner_if #(
  parameter int DIGITS = 4
);

  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [DIGITS-1:0]     anode;
  logic [6:0]            data;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output enable, load, value, dp_in, blank_lz,
    input  anode, data, dp, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in, blank_lz,
    output anode, data, dp, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment pattern, active-high {g,f,e,d,c,b,a}.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero blanking, per-digit decimal points and a frame_done pulse.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter bit ANODE_ACT_LO = 1'b1,
  parameter bit SEG_ACT_LO   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_scanner_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DIGITS);

  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     DIG_LAST   = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_OFF  = {DIGITS{ANODE_ACT_LO}};
  localparam logic [6:0]        DATA_OFF   = seg_polarity(SEG_OFF, SEG_ACT_LO);
  localparam logic              DP_OFF     = SEG_ACT_LO;

  logic [PW-1:0]       presc;
  logic [DW-1:0]       dig;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_v;
  logic [4*DIGITS-1:0] act_val;
  logic [DIGITS-1:0]   act_dp;

  logic [DIGITS-1:0]   anode_r;
  logic [6:0]          data_r;
  logic                dp_r;
  logic                frame_done_r;

  logic                presc_last;
  logic                wrap;
  logic [DIGITS-1:0]   blank;
  logic                upper_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lit;
  logic [6:0]          cur_seg;
  logic [DIGITS-1:0]   dig_sel;

  assign presc_last = (presc == PRESC_LAST);
  assign wrap       = bus.enable && presc_last && (dig == DIG_LAST);

  // A digit is blanked only while it and every more-significant nibble are zero.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (act_val[4*k +: 4] == 4'h0);
      blank[k]   = bus.blank_lz & upper_zero;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig == DW'(k)) begin
        cur_nib = act_val[4*k +: 4];
        cur_dp  = act_dp[k];
      end
    end
  end

  assign cur_lit = bus.enable & ~blank[dig];
  assign dig_sel = {{(DIGITS-1){1'b0}}, 1'b1} << dig;

  seg7_decode u_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Active buffer only changes in the wrap cycle so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      dig          <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      pend_v       <= 1'b0;
      act_val      <= '0;
      act_dp       <= '0;
      anode_r      <= ANODE_OFF;
      data_r       <= DATA_OFF;
      dp_r         <= DP_OFF;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.enable) begin
        presc <= presc_last ? '0 : presc + 1'b1;
        if (presc_last) begin
          dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
        end
      end

      frame_done_r <= wrap;

      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end

      if (wrap) begin
        pend_v <= 1'b0;
        if (bus.load) begin
          act_val <= bus.value;
          act_dp  <= bus.dp_in;
        end else if (pend_v) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
        end
      end else if (bus.load) begin
        pend_v <= 1'b1;
      end

      anode_r <= cur_lit ? (ANODE_ACT_LO ? ~dig_sel : dig_sel) : ANODE_OFF;
      data_r  <= cur_lit ? seg_polarity(cur_seg, SEG_ACT_LO) : DATA_OFF;
      dp_r    <= cur_lit ? (cur_dp ^ SEG_ACT_LO) : DP_OFF;
    end
  end

  assign bus.anode      = anode_r;
  assign bus.data       = data_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner (DIGITS=4, PRESCALE=4, active-low outputs).
// Expected digit slots and frame_done times are queued up front; a monitor pops them as they appear.
module tb_seg_display_scanner;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] data;
    logic       dp;
  } slot_t;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;

  slot_t      slot_q[$];
  int         fd_q[$];
  slot_t      got_s;
  slot_t      exp_s;
  int         exp_cyc;
  logic [3:0] prev_anode = 4'hF;

  seg_display_scanner_if #(.DIGITS(4)) bus ();

  seg_display_scanner #(
    .DIGITS       (4),
    .PRESCALE     (4),
    .ANODE_ACT_LO (1'b1),
    .SEG_ACT_LO   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A new lit anode pattern marks the start of a digit slot; frame_done is matched by cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bus.anode != 4'hF && bus.anode != prev_anode) begin
        got_s = '{anode: bus.anode, data: bus.data, dp: bus.dp};
        n_checks++;
        if (slot_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL slot_underflow: unexpected anode=%b data=%h dp=%b at cyc %0d",
                   got_s.anode, got_s.data, got_s.dp, cyc);
        end else begin
          exp_s = slot_q.pop_front();
          if (got_s !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL slot: got anode=%b data=%h dp=%b, expected anode=%b data=%h dp=%b at cyc %0d",
                     got_s.anode, got_s.data, got_s.dp, exp_s.anode, exp_s.data, exp_s.dp, cyc);
          end
        end
      end
      prev_anode = bus.anode;

      if (bus.frame_done === 1'b1) begin
        n_checks++;
        if (fd_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL frame_done_unexpected: pulse at cyc %0d, none expected", cyc);
        end else begin
          exp_cyc = fd_q.pop_front();
          if (cyc != exp_cyc) begin
            n_fail++;
            $display("[TB] FAIL frame_done_time: pulse at cyc %0d, expected cyc %0d", cyc, exp_cyc);
          end
        end
      end
    end
  end

  function automatic void push_slot(input int k, input logic [6:0] data, input logic dp_on);
    slot_t      s;
    logic [3:0] one;
    one     = 4'b0001;
    s.anode = ~(one << k);
    s.data  = data;
    s.dp    = ~dp_on;
    slot_q.push_back(s);
  endfunction

  function automatic void push_frame(input logic [6:0] d0, input logic [6:0] d1,
                                     input logic [6:0] d2, input logic [6:0] d3,
                                     input logic [3:0] dps);
    push_slot(0, d0, dps[0]);
    push_slot(1, d1, dps[1]);
    push_slot(2, d2, dps[2]);
    push_slot(3, d3, dps[3]);
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Returns just after scan edge n-1, so inputs driven now are sampled at scan edge n.
  task automatic goto_edge(input int n);
    while (cyc < base + n - 1) step_clk();
  endtask

  task automatic apply_stimulus(input int n, input logic [15:0] val, input logic [3:0] dps);
    goto_edge(n);
    bus.value = val;
    bus.dp_in = dps;
    bus.load  = 1'b1;
    step_clk();
    bus.load  = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at cyc %0d", name, got, exp, cyc);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.dp_in    = 4'b0000;
    bus.blank_lz = 1'b0;

    // F0 zeros, F1/F2 12AF, F3 0030 blanked, F4 0000 blanked
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0100);
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b0100);
    push_slot(0, 7'h40, 1'b0);
    push_slot(1, 7'h30, 1'b0);
    push_slot(0, 7'h40, 1'b0);
    // F5 B0E7 (A=5555 must never show), F6 9D48
    push_frame(7'h78, 7'h06, 7'h40, 7'h03, 4'b0000);
    push_frame(7'h00, 7'h19, 7'h21, 7'h10, 4'b1001);
    // F7 9D48 with digit 2 split by the freeze, F8 cut by reset at digit 2
    push_slot(0, 7'h00, 1'b1);
    push_slot(1, 7'h19, 1'b0);
    push_slot(2, 7'h21, 1'b0);
    push_slot(2, 7'h21, 1'b0);
    push_slot(3, 7'h10, 1'b1);
    push_slot(0, 7'h00, 1'b1);
    push_slot(1, 7'h19, 1'b0);
    push_slot(2, 7'h21, 1'b0);
    // Two frames after the mid-scan reset: only digit 0 showing 0
    push_slot(0, 7'h40, 1'b0);
    push_slot(0, 7'h40, 1'b0);

    repeat (3) step_clk();
    base = cyc;
    foreach (fd_q[i]) fd_q.delete(i);
    fd_q.push_back(base + 16);
    fd_q.push_back(base + 32);
    fd_q.push_back(base + 48);
    fd_q.push_back(base + 64);
    fd_q.push_back(base + 80);
    fd_q.push_back(base + 96);
    fd_q.push_back(base + 112);
    fd_q.push_back(base + 138);

    check_output("reset_state", {bus.anode, bus.data, bus.dp, bus.frame_done},
                 {4'hF, 7'h7F, 1'b1, 1'b0});
    reset = 1'b0;

    apply_stimulus(2, 16'h12AF, 4'b0100);

    goto_edge(34);
    bus.blank_lz = 1'b1;
    apply_stimulus(34, 16'h0030, 4'b0000);
    apply_stimulus(50, 16'h0000, 4'b0000);

    apply_stimulus(69, 16'h5555, 4'b1111);
    apply_stimulus(73, 16'hB0E7, 4'b0000);
    apply_stimulus(96, 16'h9D48, 4'b1001);

    goto_edge(122);
    bus.enable = 1'b0;
    step_clk();
    check_output("disable_next_cycle", {8'h00, bus.anode, bus.frame_done}, {8'h00, 4'hF, 1'b0});
    goto_edge(132);
    check_output("disable_hold", {8'h00, bus.anode, bus.frame_done}, {8'h00, 4'hF, 1'b0});
    bus.enable = 1'b1;
    step_clk();
    check_output("resume_digit2", {8'h00, bus.anode, bus.frame_done}, {8'h00, 4'b1011, 1'b0});

    apply_stimulus(140, 16'h7777, 4'b1111);
    goto_edge(148);
    reset = 1'b1;
    step_clk();
    check_output("reset_mid_scan", {bus.anode, bus.data, bus.dp, bus.frame_done},
                 {4'hF, 7'h7F, 1'b1, 1'b0});
    step_clk();
    reset = 1'b0;
    base  = cyc;
    fd_q.push_back(base + 16);
    fd_q.push_back(base + 32);

    goto_edge(34);
    check_output("slot_queue_drained", 13'(slot_q.size()), 13'd0);
    check_output("frame_done_queue_drained", 13'(fd_q.size()), 13'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
